// File: rtl/pkt_chk_pkg.sv
`default_nettype none
// ============================================================================
// pkt_chk_pkg : shared error codes and default widths for pkt_checker_q
// Optional feature macro: PKT_PARITY_EN.   Rev 1.0
// ============================================================================
package pkt_chk_pkg;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_HDR  = 2'd1,
        ERR_PAR  = 2'd2
    } err_code_e;

    localparam int           c_HDR_W   = 4;
    localparam logic [3:0]   c_HDR_VAL = 4'hE;
    localparam int           c_ADDR_W  = 8;
    localparam int           c_DATA_W  = 16;
    localparam int           c_DEPTH   = 4;
    localparam int           c_CNT_W   = 16;

`ifdef PKT_PARITY_EN
    localparam int           c_PAR_W   = 1;
`else
    localparam int           c_PAR_W   = 0;
`endif

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : power-of-two synchronous FIFO with a registered head output
// Rev 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic               w_push, w_pop;

    assign full_o  = (count_q == (c_PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = head_q;
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    // Head register holds the entry that will be at the front after this edge,
    // bypassing the write data when the FIFO is (about to be) otherwise empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + c_PTR_W'(w_push);
        rd_ptr_d = rd_ptr_q + c_PTR_W'(w_pop);
        count_d  = count_q + (c_PTR_W+1)'(w_push) - (c_PTR_W+1)'(w_pop);
        head_d   = '0;
        if (count_d != '0) begin
            if ((count_q - (c_PTR_W+1)'(w_pop)) == '0) begin
                head_d = wdata_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_checker_q.sv
`default_nettype none
// ============================================================================
// pkt_checker_q : header/parity packet checker feeding a RAM write queue
// Optional feature macro: PKT_PARITY_EN (even parity in data_in MSB). Rev 1.0
// ============================================================================
module pkt_checker_q
    import pkt_chk_pkg::*;
#(
    parameter int               HDR_W   = c_HDR_W,
    parameter logic [HDR_W-1:0] HDR_VAL = c_HDR_VAL,
    parameter int               ADDR_W  = c_ADDR_W,
    parameter int               DATA_W  = c_DATA_W,
    parameter int               DEPTH   = c_DEPTH,
    parameter int               CNT_W   = c_CNT_W,
    localparam int              PKT_W   = HDR_W + ADDR_W + DATA_W + c_PAR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PKT_W-1:0]  data_in,
    output logic              ram_en,
    input  logic              ram_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  good_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int c_ENT_W = ADDR_W + DATA_W;

    logic               w_full, w_empty;
    logic               w_xfer, w_hdr_ok, w_par_ok, w_good, w_bad;
    logic [c_ENT_W-1:0] w_head;
    err_code_e          w_code;
    err_code_e          err_code_q;
    logic               error_q;
    logic [CNT_W-1:0]   good_q, good_d, errc_q, errc_d;

    assign in_ready = !w_full && !rst;
    assign w_xfer   = in_valid && in_ready;
    assign w_hdr_ok = (data_in[HDR_W-1:0] == HDR_VAL);

`ifdef PKT_PARITY_EN
    assign w_par_ok = ~^data_in;
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_good = w_xfer && w_par_ok && w_hdr_ok;
    assign w_bad  = w_xfer && !(w_par_ok && w_hdr_ok);
    assign w_code = !w_par_ok ? ERR_PAR : ERR_HDR;

    sync_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_good),
        .wdata_i (data_in[HDR_W +: c_ENT_W]),
        .pop_i   (ram_en && ram_ready),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    assign ram_en      = !w_empty;
    assign ram_address = w_head[ADDR_W-1:0];
    assign ram_data    = w_head[ADDR_W +: DATA_W];

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        good_d = good_q;
        errc_d = errc_q;
        if (w_good && (good_q != '1)) begin
            good_d = good_q + CNT_W'(1);
        end
        if (w_bad && (errc_q != '1)) begin
            errc_d = errc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            good_q     <= '0;
            errc_q     <= '0;
        end else begin
            error_q <= w_bad;
            if (w_bad) begin
                err_code_q <= w_code;
            end
            good_q <= good_d;
            errc_q <= errc_d;
        end
    end

    assign error      = error_q;
    assign err_code   = err_code_q;
    assign good_count = good_q;
    assign err_count  = errc_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_checker_q.sv
`default_nettype none
// ============================================================================
// tb_pkt_checker_q : directed vector bench for pkt_checker_q
// Optional feature macro: PKT_PARITY_EN.   Rev 1.0
// ============================================================================
module tb_pkt_checker_q;
    import pkt_chk_pkg::*;

    localparam int PW = 28 + c_PAR_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [PW-1:0] data_in;
    logic          ram_ready;
    logic          in_ready, ram_en, error;
    logic [7:0]    ram_address;
    logic [15:0]   ram_data;
    logic [1:0]    err_code;
    logic [15:0]   good_count, err_count;

    // Narrow-counter instance sharing the same stimulus, to reach saturation.
    logic          s_in_ready, s_ram_en, s_error;
    logic [7:0]    s_ram_address;
    logic [15:0]   s_ram_data;
    logic [1:0]    s_err_code;
    logic [2:0]    s_good, s_errc;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pkt_checker_q dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .ram_en(ram_en), .ram_ready(ram_ready),
        .ram_address(ram_address), .ram_data(ram_data), .error(error),
        .err_code(err_code), .good_count(good_count), .err_count(err_count)
    );

    pkt_checker_q #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .data_in(data_in), .ram_en(s_ram_en), .ram_ready(ram_ready),
        .ram_address(s_ram_address), .ram_data(s_ram_data), .error(s_error),
        .err_code(s_err_code), .good_count(s_good), .err_count(s_errc)
    );

    typedef struct {
        logic        rst, vld;
        logic [3:0]  hdr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        rr;
        logic        e_en;
        logic [7:0]  e_addr;
        logic [15:0] e_data;
        logic        e_err;
        logic [1:0]  e_code;
        logic [15:0] e_good, e_errc;
        logic        e_rdy;
    } vec_t;

    vec_t tv [12];

    function automatic logic [PW-1:0] mk(input logic [3:0] h, input logic [7:0] a,
                                         input logic [15:0] d);
        logic [27:0] b;
        b = {d, a, h};
`ifdef PKT_PARITY_EN
        return {^b, b};
`else
        return b;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [3:0] h, input logic [7:0] a,
                        input logic [15:0] d);
        in_valid = v;
        data_in  = mk(h, a, d);
    endtask

    initial begin
        logic [7:0] exp_a [5];

        //          rst vld hdr   addr   data      rr   en   addr   data      err code good    errc   rdy
        tv[0]  = '{1'b1, 1'b0, 4'h0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 4'h0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 2'd0, 16'd0, 16'd0, 1'b1};
        tv[2]  = '{1'b0, 1'b1, 4'hE, 8'h3C, 16'hBEEF, 1'b1, 1'b1, 8'h3C, 16'hBEEF, 1'b0, 2'd0, 16'd1, 16'd0, 1'b1};
        tv[3]  = '{1'b0, 1'b1, 4'h5, 8'h11, 16'h2222, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 2'd1, 16'd1, 16'd1, 1'b1};
        tv[4]  = '{1'b0, 1'b0, 4'h5, 8'hFF, 16'hFFFF, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 2'd1, 16'd1, 16'd1, 1'b1};
        tv[5]  = '{1'b0, 1'b1, 4'hE, 8'h01, 16'h1111, 1'b0, 1'b1, 8'h01, 16'h1111, 1'b0, 2'd1, 16'd2, 16'd1, 1'b1};
        tv[6]  = '{1'b0, 1'b1, 4'hE, 8'h02, 16'h2222, 1'b0, 1'b1, 8'h01, 16'h1111, 1'b0, 2'd1, 16'd3, 16'd1, 1'b1};
        tv[7]  = '{1'b0, 1'b0, 4'h0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h02, 16'h2222, 1'b0, 2'd1, 16'd3, 16'd1, 1'b1};
        tv[8]  = '{1'b0, 1'b1, 4'hE, 8'h03, 16'h3333, 1'b1, 1'b1, 8'h03, 16'h3333, 1'b0, 2'd1, 16'd4, 16'd1, 1'b1};
        tv[9]  = '{1'b0, 1'b1, 4'hA, 8'h09, 16'h9999, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 2'd1, 16'd4, 16'd2, 1'b1};
        tv[10] = '{1'b0, 1'b1, 4'hE, 8'h04, 16'h4444, 1'b0, 1'b1, 8'h04, 16'h4444, 1'b0, 2'd1, 16'd5, 16'd2, 1'b1};
        tv[11] = '{1'b0, 1'b0, 4'h0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 2'd1, 16'd5, 16'd2, 1'b1};

        rst = 1'b1; in_valid = 1'b0; data_in = '0; ram_ready = 1'b0;

        for (int i = 0; i < 12; i++) begin
            rst       = tv[i].rst;
            ram_ready = tv[i].rr;
            beat(tv[i].vld, tv[i].hdr, tv[i].addr, tv[i].data);
            step();
            chk($sformatf("v%0d ram_en", i), ram_en, tv[i].e_en);
            if (tv[i].e_en) begin
                chk($sformatf("v%0d ram_address", i), ram_address, tv[i].e_addr);
                chk($sformatf("v%0d ram_data", i), ram_data, tv[i].e_data);
            end
            chk($sformatf("v%0d error", i), error, tv[i].e_err);
            chk($sformatf("v%0d err_code", i), err_code, tv[i].e_code);
            chk($sformatf("v%0d good_count", i), good_count, tv[i].e_good);
            chk($sformatf("v%0d err_count", i), err_count, tv[i].e_errc);
            chk($sformatf("v%0d in_ready", i), in_ready, tv[i].e_rdy);
        end

        // Fill to full with RAM stalled, offer a fifth beat, then drain.
        ram_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 4'hE, 8'h10 + 8'(i), 16'hA000 + 16'(i));
            step();
            chk($sformatf("fill%0d in_ready", i), in_ready, (i < 3) ? 1'b1 : 1'b0);
            chk($sformatf("fill%0d head", i), ram_address, 8'h10);
        end
        beat(1'b1, 4'hE, 8'h14, 16'hA004);
        step();
        chk("full hold in_ready", in_ready, 1'b0);
        chk("full hold good_count", good_count, 16'd9);
        chk("full hold head", ram_data, 16'hA000);
        ram_ready = 1'b1;
        exp_a = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        for (int k = 0; k < 6; k++) begin
            logic xfer;
            xfer = in_valid && in_ready;
            chk($sformatf("drain%0d ram_en", k), ram_en, (k < 5) ? 1'b1 : 1'b0);
            if (k < 5) begin
                chk($sformatf("drain%0d addr", k), ram_address, exp_a[k]);
                chk($sformatf("drain%0d data", k), ram_data, 16'hA000 + 16'(exp_a[k] - 8'h10));
            end
            if (k == 1) chk("drain in_ready back", in_ready, 1'b1);
            step();
            if (xfer) in_valid = 1'b0;
        end
        chk("drain good_count", good_count, 16'd10);

        // Six bad beats: main counter 8, 3-bit instance pinned at 7.
        for (int i = 0; i < 6; i++) begin
            beat(1'b1, 4'h3, 8'(i), 16'h0);
            step();
        end
        beat(1'b0, 4'h3, 8'h00, 16'h0);
        chk("last bad error", error, 1'b1);
        step();
        chk("pulse width", error, 1'b0);
        chk("err_count 8", err_count, 16'd8);
        chk("sat err_count", s_errc, 3'd7);
        chk("sat good_count", s_good, 3'd7);

        // Reset with three entries queued and a valid beat presented.
        ram_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 4'hE, 8'h20 + 8'(i), 16'hC000 + 16'(i));
            step();
        end
        chk("pre-rst good_count", good_count, 16'd13);
        rst = 1'b1;
        beat(1'b1, 4'hE, 8'h23, 16'hC003);
        step();
        chk("rst ram_en", ram_en, 1'b0);
        chk("rst ram_address", ram_address, 8'h00);
        chk("rst ram_data", ram_data, 16'h0000);
        chk("rst err_code", err_code, 2'd0);
        chk("rst good_count", good_count, 16'd0);
        chk("rst err_count", err_count, 16'd0);
        chk("rst in_ready", in_ready, 1'b0);
        rst = 1'b0;
        ram_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post-rst%0d ram_en", i), ram_en, 1'b0);
            chk($sformatf("post-rst%0d in_ready", i), in_ready, 1'b1);
        end
        chk("post-rst good_count", good_count, 16'd0);

`ifdef PKT_PARITY_EN
        in_valid = 1'b1;
        data_in  = mk(4'hE, 8'h55, 16'h1234) ^ {1'b1, {(PW-1){1'b0}}};
        step();
        chk("par error", error, 1'b1);
        chk("par err_code", err_code, 2'd2);
        chk("par ram_en", ram_en, 1'b0);
        chk("par err_count", err_count, 16'd1);
        data_in  = mk(4'h5, 8'h55, 16'h1234) ^ {1'b1, {(PW-1){1'b0}}};
        step();
        chk("par+hdr err_code", err_code, 2'd2);
        chk("par+hdr good_count", good_count, 16'd0);
        in_valid = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_checker_q.md
# pkt_checker_q

Parametrised packet checker with a write queue. It accepts packet beats over a valid/ready handshake, validates the header field and buffers good packets in a DEPTH-entry FIFO. It drains them to a RAM write port that has its own ready signal. It sits between the packet source and the RAM, and reports per-packet errors through a one-cycle error pulse and saturating counters.

## Interface
- HDR_W, 4, header field width
- HDR_VAL, 4'hE, header value that marks a valid packet
- ADDR_W, 8, RAM address width
- DATA_W, 16, RAM data width
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, statistics counter width
- PKT_W, derived: HDR_W+ADDR_W+DATA_W, plus 1 when PKT_PARITY_EN is defined
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  packet beat is valid
- in_ready  out  1  block can accept a beat
- data_in  in  PKT_W  packet: [HDR_W-1:0] header, next ADDR_W bits address, next DATA_W bits data, MSB parity (with macro only)
- ram_en  out  1  RAM write request; asserted while the FIFO is non-empty
- ram_ready  in  1  RAM takes the write this cycle
- ram_address  out  ADDR_W  write address of the FIFO head
- ram_data  out  DATA_W  write data of the FIFO head
- error  out  1  one-cycle pulse for a rejected beat
- err_code  out  2  reason: 0 none, 1 header, 2 parity; held until the next rejection
- good_count  out  CNT_W  accepted-good packets, saturating
- err_count  out  CNT_W  rejected packets, saturating

## Operation
- Transfer happens when in_valid && in_ready.
- in_ready = !full. It is low during rst.
- For each transferred beat, the header field is compared with HDR_VAL.
  - Match: the {address, data} pair is pushed into the FIFO, and good_count increments.
  - Mismatch: the beat is dropped, error pulses, err_code=1, and err_count increments.
- Beats with in_valid low are ignored and produce no error. This is a change from free-running sampling.
- The FIFO head drives ram_address/ram_data.
  - ram_en = !empty.
  - A pop happens on ram_en && ram_ready.
  - The head stays stable while ram_en is high and ram_ready is low.
- Push and pop in the same cycle: occupancy is unchanged. Push is impossible when full.
- Both counters stop at 2^CNT_W−1 and do not wrap.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Reset values:
  - ram_en=0, ram_address=0, ram_data=0.
  - error=0, err_code=0.
  - good_count=0, err_count=0.
  - FIFO empty. in_ready goes to 1 on the first cycle after rst deasserts.
- rst asserted in mid-operation flushes all queued entries without issuing RAM writes. A beat presented in the rst cycle is discarded.

## Timing
- Beat transferred in cycle N:
  - error, err_code and counters update at the edge ending cycle N, visible in N+1.
  - A good entry is visible on ram_en/ram_address/ram_data in N+1 at the earliest. Latency is 1 cycle when the FIFO is empty.
- Pop in cycle M: the next entry is presented in M+1. ram_en drops in M+1 if the FIFO became empty.
- in_ready goes low in the cycle after the push that fills the FIFO. It returns high in the cycle after the first pop from full.
- Sustained throughput is one packet per cycle when ram_ready is held high.

## Configuration
- PKT_PARITY_EN defined:
  - The data_in MSB is an even-parity bit over data_in[PKT_W-2:0].
  - A parity mismatch rejects the beat with err_code=2. Parity is checked before the header, so when both fail err_code=2.
- PKT_PARITY_EN undefined: there is no parity bit, PKT_W excludes it, and err_code never takes the value 2.

## Structure
- Package pkt_chk_pkg contains:
  - the err_code enum typedef (ERR_NONE, ERR_HDR, ERR_PAR);
  - default parameter constants for HDR_VAL and the widths.
- Sub-module sync_fifo:
  - parameters WIDTH, DEPTH;
  - push/pop/full/empty;
  - registered head outputs.
- The top level holds the check logic, the counters and the error pulse.

## Test plan
- After rst, send header 4'hE, address 8'h3C, data 16'hBEEF with ram_ready=1 → next cycle ram_en=1, ram_address=8'h3C, ram_data=16'hBEEF; good_count=1; error=0.
- Send header 4'h5 → next cycle error=1 for exactly one cycle, err_code=1, err_count=1, ram_en stays 0.
- Hold ram_ready=0 and send 5 good beats with DEPTH=4 → in_ready goes low after the 4th. Then raise ram_ready → writes come out in order with no loss, one per cycle, and in_ready returns.
- Hold in_valid=0 with garbage on data_in → no error, counters unchanged.
- Assert rst with 3 entries queued → ram_en=0 and all outputs zero next cycle, and no queued entry is written afterwards.
- With PKT_PARITY_EN, send a good header with the parity bit flipped → error=1, err_code=2, nothing enqueued. With err_count preset near max, send extra bad beats → err_count saturates at 16'hFFFF.
